// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_pkg
//  Description : Shared types and encodings for the multicycle RV32I control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_UPPER    = 4'd9,
        S_ALUWB    = 4'd10,
        S_JAL      = 4'd11,
        S_JALR     = 4'd12,
        S_BRANCH   = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_XOR  = 4'd4;
    localparam logic [3:0] c_ALU_SLT  = 4'd5;
    localparam logic [3:0] c_ALU_SLTU = 4'd6;
    localparam logic [3:0] c_ALU_SLL  = 4'd7;
    localparam logic [3:0] c_ALU_SRL  = 4'd8;
    localparam logic [3:0] c_ALU_SRA  = 4'd9;

    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_J = 3'b011;
    localparam logic [2:0] c_IMM_U = 3'b100;

    // SRCA_ZERO feeds a constant zero so lui can reuse the imm+operand path.
    localparam logic [1:0] c_SRCA_PC    = 2'b00;
    localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] c_SRCA_RS1   = 2'b10;
    localparam logic [1:0] c_SRCA_ZERO  = 2'b11;

    localparam logic [1:0] c_SRCB_RS2  = 2'b00;
    localparam logic [1:0] c_SRCB_IMM  = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR = 2'b10;

    localparam logic [1:0] c_RES_ALUOUT = 2'b00;
    localparam logic [1:0] c_RES_MEM    = 2'b01;
    localparam logic [1:0] c_RES_ALU    = 2'b10;

    localparam logic [1:0] c_TRAP_NONE    = 2'b00;
    localparam logic [1:0] c_TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] c_TRAP_BUS     = 2'b10;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit_if
//  Description : Instruction fields, memory handshake and datapath strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if #(
    parameter int ALU_CTRL_W = 4
);
    logic [6:0]            op;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  alu_zero;
    logic                  mem_ready;
    logic                  mem_req;
    logic                  mem_write;
    logic                  adr_src;
    logic                  ir_write;
    logic                  pc_write;
    logic                  reg_write;
    logic [1:0]            alu_src_a;
    logic [1:0]            alu_src_b;
    logic [1:0]            result_src;
    logic [2:0]            imm_src;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  trap;
    logic [1:0]            trap_cause;

    modport master (
        input  op, funct3, funct7, alu_zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control,
               trap, trap_cause
    );

    modport slave (
        output op, funct3, funct7, alu_zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control,
               trap, trap_cause
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit_alu_decoder_ext.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder_ext
//  Description : funct3/funct7/op -> 4-bit ALU code plus illegal-encoding flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder_ext
    import multicycle_ctrl_pkg::*;
#(
    parameter int FULL_RV32I = 1
) (
    input  wire logic [6:0] op,
    input  wire logic [2:0] funct3,
    input  wire logic [6:0] funct7,
    output logic      [3:0] alu_code,
    output logic            illegal
);

    localparam bit c_FULL = (FULL_RV32I != 0);

    logic       w_is_r;
    logic       w_f7_zero;
    logic       w_f7_alt;
    logic [3:0] w_code;
    logic       w_bad;

    assign w_is_r    = (op == c_OP_R);
    assign w_f7_zero = (funct7 == 7'b0000000);
    assign w_f7_alt  = (funct7 == 7'b0100000);

    // Shift immediates carry funct7 in the upper imm bits, so they are checked
    // for both R and I; other I-type encodings treat funct7 as immediate.
    always_comb begin
        w_code = c_ALU_ADD;
        w_bad  = 1'b0;
        case (funct3)
            3'b000: begin
                if (w_is_r) begin
                    if (w_f7_alt)        w_code = c_ALU_SUB;
                    else if (!w_f7_zero) w_bad  = 1'b1;
                end
            end
            3'b001: begin
                w_code = c_ALU_SLL;
                w_bad  = !w_f7_zero;
            end
            3'b010: begin
                w_code = c_ALU_SLT;
                w_bad  = w_is_r && !w_f7_zero;
            end
            3'b011: begin
                w_code = c_ALU_SLTU;
                w_bad  = w_is_r && !w_f7_zero;
            end
            3'b100: begin
                w_code = c_ALU_XOR;
                w_bad  = w_is_r && !w_f7_zero;
            end
            3'b101: begin
                w_code = w_f7_alt ? c_ALU_SRA : c_ALU_SRL;
                w_bad  = !(w_f7_zero || w_f7_alt);
            end
            3'b110: begin
                w_code = c_ALU_OR;
                w_bad  = w_is_r && !w_f7_zero;
            end
            default: begin
                w_code = c_ALU_AND;
                w_bad  = w_is_r && !w_f7_zero;
            end
        endcase
        if (!c_FULL && (funct3 == 3'b001 || funct3 == 3'b011 ||
                        funct3 == 3'b100 || funct3 == 3'b101)) begin
            w_bad = 1'b1;
        end
    end

    assign illegal  = w_bad;
    assign alu_code = w_bad ? c_ALU_ADD : w_code;

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : Multicycle RV32I control FSM with bounded memory wait and traps.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int FULL_RV32I = 1,
    parameter int MEM_TMO    = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    multicycle_control_unit_if.master bus
);

    localparam int                 c_CNT_W    = $clog2(MEM_TMO);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(MEM_TMO - 1);

    state_t               r_state;
    state_t               w_next;
    logic [c_CNT_W-1:0]   r_wait_cnt;
    logic                 r_trap;
    logic [1:0]           r_trap_cause;
    logic [1:0]           w_next_cause;
    logic                 w_in_mem;
    logic                 w_timeout;
    logic                 w_branch_ok;
    logic [3:0]           w_dec_code;
    logic                 w_dec_illegal;

    logic                 w_mem_req;
    logic                 w_mem_write;
    logic                 w_adr_src;
    logic                 w_ir_write;
    logic                 w_pc_write;
    logic                 w_reg_write;
    logic [1:0]           w_alu_src_a;
    logic [1:0]           w_alu_src_b;
    logic [1:0]           w_result_src;
    logic [2:0]           w_imm_src;
    logic [3:0]           w_alu_code;
    logic [ALU_CTRL_W-1:0] w_alu_control;

    alu_decoder_ext #(
        .FULL_RV32I (FULL_RV32I)
    ) u_alu_dec (
        .op       (bus.op),
        .funct3   (bus.funct3),
        .funct7   (bus.funct7),
        .alu_code (w_dec_code),
        .illegal  (w_dec_illegal)
    );

    assign w_in_mem    = is_mem_state(r_state);
    assign w_timeout   = w_in_mem && !bus.mem_ready && (r_wait_cnt == c_TMO_LAST);
    assign w_branch_ok = (bus.funct3[2:1] != 2'b01);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RST;
            r_wait_cnt   <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= c_TRAP_NONE;
        end else begin
            r_state <= w_next;
            // Any state change clears the counter, so every mem state is entered at 0.
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_in_mem && !bus.mem_ready) begin
                r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
            end
            if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_next_cause;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_next_cause = c_TRAP_NONE;
        case (r_state)
            S_RST:    w_next = S_FETCH;
            S_FETCH, S_MEMREAD, S_MEMWRITE: begin
                if (bus.mem_ready) begin
                    w_next = (r_state == S_FETCH)   ? S_DECODE :
                             (r_state == S_MEMREAD) ? S_MEMWB  : S_FETCH;
                end else if (w_timeout) begin
                    w_next       = S_TRAP;
                    w_next_cause = c_TRAP_BUS;
                end
            end
            S_DECODE: begin
                case (bus.op)
                    c_OP_LOAD, c_OP_STORE: w_next = S_MEMADR;
                    c_OP_R:                w_next = S_EXECR;
                    c_OP_I:                w_next = S_EXECI;
                    c_OP_JAL:              w_next = S_JAL;
                    c_OP_JALR:             w_next = S_JALR;
                    c_OP_LUI, c_OP_AUIPC:  w_next = S_UPPER;
                    c_OP_BRANCH:           w_next = w_branch_ok ? S_BRANCH : S_TRAP;
                    default:               w_next = S_TRAP;
                endcase
                if (w_next == S_TRAP) w_next_cause = c_TRAP_ILLEGAL;
            end
            S_MEMADR: w_next = (bus.op == c_OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMWB:  w_next = S_FETCH;
            S_EXECR, S_EXECI: begin
                if (w_dec_illegal) begin
                    w_next       = S_TRAP;
                    w_next_cause = c_TRAP_ILLEGAL;
                end else begin
                    w_next = S_ALUWB;
                end
            end
            S_UPPER, S_JAL, S_JALR: w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_RST;
        endcase
    end

    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = c_SRCA_PC;
        w_alu_src_b  = c_SRCB_RS2;
        w_result_src = c_RES_ALUOUT;
        w_imm_src    = c_IMM_I;
        w_alu_code   = c_ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write  = 1'b1;
                    w_pc_write  = 1'b1;
                    w_alu_src_b = c_SRCB_FOUR;
                end
            end
            S_DECODE: begin
                w_alu_src_a = c_SRCA_OLDPC;
                w_alu_src_b = c_SRCB_IMM;
                w_imm_src   = c_IMM_B;
            end
            S_MEMADR: begin
                w_alu_src_a = c_SRCA_RS1;
                w_alu_src_b = c_SRCB_IMM;
                w_imm_src   = (bus.op == c_OP_STORE) ? c_IMM_S : c_IMM_I;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_result_src = c_RES_MEM;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
            end
            S_EXECR: begin
                w_alu_src_a = c_SRCA_RS1;
                w_alu_code  = w_dec_code;
            end
            S_EXECI: begin
                w_alu_src_a = c_SRCA_RS1;
                w_alu_src_b = c_SRCB_IMM;
                w_alu_code  = w_dec_code;
            end
            S_UPPER: begin
                w_alu_src_a = (bus.op == c_OP_LUI) ? c_SRCA_ZERO : c_SRCA_OLDPC;
                w_alu_src_b = c_SRCB_IMM;
                w_imm_src   = c_IMM_U;
            end
            S_ALUWB:  w_reg_write = 1'b1;
            S_JAL, S_JALR: begin
                w_pc_write  = 1'b1;
                w_alu_src_a = c_SRCA_OLDPC;
                w_alu_src_b = c_SRCB_FOUR;
                w_imm_src   = (r_state == S_JAL) ? c_IMM_J : c_IMM_I;
            end
            S_BRANCH: begin
                w_alu_src_a = c_SRCA_RS1;
                w_alu_code  = (bus.funct3[2:1] == 2'b11) ? c_ALU_SLTU :
                              (bus.funct3[2])            ? c_ALU_SLT  : c_ALU_SUB;
                // Odd funct3 inverts the sense; the lt variants test a nonzero SLT result.
                w_pc_write  = bus.alu_zero ^ bus.funct3[0] ^ bus.funct3[2];
            end
            default: ;
        endcase
    end

    generate
        if (ALU_CTRL_W > 4) begin : g_alu_wide
            assign w_alu_control = {{(ALU_CTRL_W-4){1'b0}}, w_alu_code};
        end else begin : g_alu_exact
            assign w_alu_control = w_alu_code[ALU_CTRL_W-1:0];
        end
    endgenerate

    assign bus.mem_req     = w_mem_req;
    assign bus.mem_write   = w_mem_write;
    assign bus.adr_src     = w_adr_src;
    assign bus.ir_write    = w_ir_write;
    assign bus.pc_write    = w_pc_write;
    assign bus.reg_write   = w_reg_write;
    assign bus.alu_src_a   = w_alu_src_a;
    assign bus.alu_src_b   = w_alu_src_b;
    assign bus.result_src  = w_result_src;
    assign bus.imm_src     = w_imm_src;
    assign bus.alu_control = w_alu_control;
    assign bus.trap        = r_trap;
    assign bus.trap_cause  = r_trap_cause;

endmodule
`default_nettype wire
